// File: rtl/seq_cla_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// seq_sub_pkg
// Shared definitions for the sequential carry look-ahead subtractor:
//   state_t    : FSM state encoding (IDLE, RUN)
//   nchunks()  : number of CHUNK-bit slices in a NUMBITS-wide operand
//   idx_width(): width of the slice index counter (never less than 1 bit)
// -----------------------------------------------------------------------------
package seq_sub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int nchunks(input int numbits, input int chunk);
      return numbits / chunk;
   endfunction

   // A single-slice configuration still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_cla_subtractor_if.sv
// -----------------------------------------------------------------------------
// seq_cla_subtractor_if
// Request/response bundle of the sequential subtractor.
//   start, A, B, borrowin              : request (driven by the master)
//   ready, done, result, borrowout,
//   zero, overflow                     : status/response (driven by the slave)
// -----------------------------------------------------------------------------
interface seq_cla_subtractor_if #(
   parameter int NUMBITS = 16
);
   logic               start;
   logic [NUMBITS-1:0] A;
   logic [NUMBITS-1:0] B;
   logic               borrowin;
   logic               ready;
   logic               done;
   logic [NUMBITS-1:0] result;
   logic               borrowout;
   logic               zero;
   logic               overflow;

   modport master (
      output start, A, B, borrowin,
      input  ready, done, result, borrowout, zero, overflow
   );

   modport slave (
      input  start, A, B, borrowin,
      output ready, done, result, borrowout, zero, overflow
   );
endinterface

// File: rtl/seq_cla_subtractor_slice.sv
// -----------------------------------------------------------------------------
// cla_sub_slice
// Purely combinational CHUNK-bit carry look-ahead slice computing a + ~b + c_in.
//   a, b  : slice operands (b is inverted internally)
//   c_in  : incoming carry (inverted borrow)
//   d     : slice difference
//   c_out : carry out of the slice (inverted borrow out)
// -----------------------------------------------------------------------------
module cla_sub_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] d,
   output logic             c_out
);

   logic [CHUNK-1:0] w_g;
   logic [CHUNK-1:0] w_p;
   logic [CHUNK:0]   w_c;

   assign w_g = a & ~b;
   assign w_p = a ^ ~b;

   // Each carry is expanded into a flat sum of products over all lower
   // generate/propagate terms, so no carry depends on another carry.
   always_comb begin
      logic v_term;
      logic v_prop;
      w_c    = '0;
      v_term = 1'b0;
      v_prop = 1'b0;
      w_c[0] = c_in;
      for (int i = 0; i < CHUNK; i++) begin
         v_term = w_g[i];
         v_prop = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            v_term = v_term | (w_g[j] & v_prop);
            v_prop = v_prop & w_p[j];
         end
         w_c[i+1] = v_term | (c_in & v_prop);
      end
   end

   assign d     = w_p ^ w_c[CHUNK-1:0];
   assign c_out = w_c[CHUNK];

endmodule

// File: rtl/seq_cla_subtractor.sv
// -----------------------------------------------------------------------------
// seq_cla_subtractor
// Multi-cycle subtractor: result = A - B - borrowin, one CHUNK-bit look-ahead
// slice per clock, with borrow, zero and signed-overflow flags.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seq_cla_subtractor_if (start/ready/done handshake,
//              operands A/B/borrowin, registered result and flags)
// -----------------------------------------------------------------------------
module seq_cla_subtractor
   import seq_sub_pkg::*;
#(
   parameter int NUMBITS = 16,
   parameter int CHUNK   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_cla_subtractor_if.slave   bus
);

   localparam int NCHUNKS = nchunks(NUMBITS, CHUNK);
   localparam int IDX_W   = idx_width(NCHUNKS);

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_accept;
   logic                 w_last;

   logic [NUMBITS-1:0]   r_a;
   logic [NUMBITS-1:0]   r_b;
   logic                 r_a_msb;
   logic                 r_b_msb;
   logic [NUMBITS-1:0]   r_acc;
   logic                 r_carry;
   logic [IDX_W-1:0]     r_idx;

   logic [NUMBITS-1:0]   r_result;
   logic                 r_borrow;
   logic                 r_zero;
   logic                 r_ovf;
   logic                 r_done;

   logic [CHUNK-1:0]     w_d;
   logic                 w_cout;
   logic [NUMBITS-1:0]   w_diff;

   // Operands are shifted down one slice per cycle so the active slice is
   // always the low CHUNK bits; the difference is shifted in from the top so
   // that after NCHUNKS slices it sits fully aligned.
   cla_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (r_a[CHUNK-1:0]),
      .b     (r_b[CHUNK-1:0]),
      .c_in  (r_carry),
      .d     (w_d),
      .c_out (w_cout)
   );

   assign w_diff = NUMBITS'({w_d, r_acc} >> CHUNK);

   // ---- FSM state register ----
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // ---- FSM next-state logic ----
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (r_idx == IDX_W'(NCHUNKS - 1)) begin
               w_last       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // ---- Operand capture, slice iteration and completion ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_borrow <= 1'b0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_a_msb <= bus.A[NUMBITS-1];
            r_b_msb <= bus.B[NUMBITS-1];
            r_carry <= ~bus.borrowin;
            r_idx   <= '0;
         end else if (r_state == RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_acc   <= w_diff;
            r_carry <= w_cout;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
               r_result <= w_diff;
               r_borrow <= ~w_cout;
               r_zero   <= (w_diff == '0);
               r_ovf    <= (r_a_msb != r_b_msb) && (w_diff[NUMBITS-1] != r_a_msb);
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign bus.ready     = (r_state == IDLE);
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.borrowout = r_borrow;
   assign bus.zero      = r_zero;
   assign bus.overflow  = r_ovf;

endmodule
